ysyx_rob_mc: RTL
================

# ysyx_rob_mc

Parametrised reorder buffer with integrated register-alias table. It sits between the micro-op queue and the WBU/LSU/CSR commit path. It accepts one dispatch per cycle and `WB_PORTS` independent writebacks per cycle, and retires up to `CM_WIDTH` entries in order per cycle. Compared with the single-commit IQU ROB, it adds multi-port writeback, same-cycle writeback bypass to operand lookup, an occupancy counter (all `ROB_SIZE` entries usable), and a registered redirect PC.

## Interface

**Parameters**
- `ROB_SIZE`, 8: entries; power of two, ≥4.
- `REG_NUM`, 16: architectural registers tracked; indexed by `rd[$clog2(REG_NUM)-1:0]`.
- `XLEN`, 32: data width.
- `WB_PORTS`, 2: writeback ports, 1..4.
- `CM_WIDTH`, 2: commit slots, 1 or 2.
- Derived `TAGW = $clog2(ROB_SIZE)+1`. A tag is entry index + 1; tag 0 means "no producer".

**Ports** (clock and reset first)
- `clock`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `disp_valid`  in  1: uop offered for dispatch.
- `disp_ready`  out  1: ROB can accept a dispatch.
- `disp_rd`  in  5: destination register.
- `disp_pc`, `disp_pnpc`  in  XLEN each: PC and predicted next PC.
- `disp_store`, `disp_fence_i`  in  1 each: store and fence.i flags.
- `disp_tag`  out  TAGW: tag that will be assigned to the current dispatch.
- `rs1`, `rs2`  in  5 each: source lookup registers.
- `q1`, `q2`  out  TAGW each: pending producer tag; 0 if the value is available.
- `v1`, `v2`  out  XLEN each: ROB value, valid when the matching `hit1`/`hit2` is 1.
- `hit1`, `hit2`  out  1 each: value supplied by the ROB or bypass.
- `wb_valid`  in  WB_PORTS: per-port writeback valid.
- `wb_tag`  in  WB_PORTS*TAGW: per-port target tag.
- `wb_result`, `wb_npc`  in  WB_PORTS*XLEN each: per-port result and resolved next PC.
- `wb_trap`  in  WB_PORTS: per-port trap flag.
- `sq_ready`  in  1: store queue can accept a store.
- `cm_valid`  out  CM_WIDTH: per-slot commit valid.
- `cm_rd`  out  CM_WIDTH*5: per-slot destination register.
- `cm_result`, `cm_pc`  out  CM_WIDTH*XLEN each: per-slot result and PC.
- `cm_store`  out  CM_WIDTH: per-slot store flag.
- `flush`, `flush_trap`  out  1 each: redirect pulse and its trap qualifier.
- `flush_pc`  out  XLEN: redirect target.
- `count`  out  TAGW: current occupancy.

## Operation

**Entry states.** Each entry is in one of three states:
- CM: free.
- EX: dispatched, waiting for a result.
- WB: result written, ready to retire.

**Dispatch.** A dispatch fires when `disp_valid && disp_ready`.
- `disp_ready = (count != ROB_SIZE) && !flush`. It depends on registered state only; a commit in the same cycle does not free room.
- On fire: entry at `tail` is written with state EX. `tail` advances and wraps modulo `ROB_SIZE`.
- If `rd != 0`, the alias table sets `busy[rd] = 1` and `reorder[rd] = tail`. `rd = 0` is never tracked.

**Lookup.** Per source register `rs`:
- If `rs == 0` or `!busy[rs]`: `q = 0`, `hit = 0`.
- Else, if the producer entry is in WB: `q = 0`, `hit = 1`, `v` = stored value.
- Else, if any `wb_valid[p]` targets the producer tag this cycle: `q = 0`, `hit = 1`, `v = wb_result[p]`.
- Else: `q` = producer tag, `hit = 0`.

**Writeback.**
- Each valid port moves its target entry from EX to WB and stores result, npc and trap.
- A writeback to an entry that is not in EX is ignored.
- If two ports name the same tag in one cycle, the higher port index wins. This case is illegal and is flagged by an assertion.

**Commit, slot 0.**
- Fires when the head entry is in WB, `(!store || sq_ready)` holds, and `!flush`.
- The entry is a redirect if it is `fence_i`, if `trap` is set, or if `npc != pnpc`.

**Commit, slot 1** (only when `CM_WIDTH == 2`). Fires only if all of the following hold:
- slot 0 fires and slot 0 is not a redirect;
- entry `head+1` is in WB;
- entry `head+1` is not a store (at most one store per cycle).

**Retire effects.** Committed entries return to CM, `head` advances by the number of committed entries, and `count` updates by `+dispatch − commits`.
- For each committed `rd`, clear `busy[rd]` only when `reorder[rd]` equals the committing index.
- Do not clear it when a same-cycle dispatch writes the same `rd`; dispatch wins.
- If both slots hit the same `rd`, slot 1's index check applies.

**Redirect.**
- A slot-0 redirect registers `flush = 1`, `flush_pc = npc` and `flush_trap = trap` for the next cycle.
- During the flush cycle there is no dispatch and no commit; writebacks are ignored.
- At the end of the flush cycle: `head = tail = count = 0`, all entries return to CM, all `busy` bits clear, and `flush` returns to 0.

## Timing

- Reset values: `flush = 0`, `flush_trap = 0`, `flush_pc = 0`, `count = 0`, `cm_valid = 0`, `disp_ready = 1`, `disp_tag = 1`, `q1 = q2 = 0`, `hit1 = hit2 = 0`.
- Lookup outputs, `disp_tag` and `cm_*` are combinational from state and same-cycle writebacks.
- Dispatch → earliest writeback next cycle.
- Writeback → commit at the earliest one cycle later.
- Redirect commit → `flush` high for exactly 1 cycle, starting the next cycle.
- Reset asserted mid-operation behaves identically to the flush clear, including clearing a pending `flush`.

## Structure

- Package `ysyx_rob_pkg` holds `rob_state_t {CM, WB, EX}` and the `TAGW` function.
- Sub-module `ysyx_rob_rat` holds the `busy`/`reorder` alias table, dispatch set and commit clear. Parameters: `REG_NUM`, `ROB_SIZE`, `CM_WIDTH`.

## Test plan

1. **Fill and drain.** Dispatch 8 uops with `rd = 1..8`, no writebacks. Expect `count = 8`, `disp_ready = 0`, `disp_tag` sequence 1..8. Then write back tags 1..8 on alternating ports and expect 4 cycles of dual commit.
2. **Bypass.** Dispatch `rd = 5` (tag 1); next cycle look up `rs1 = 5` with `wb_valid[1]`, tag 1, result `0xDEAD`. Expect `hit1 = 1`, `v1 = 0xDEAD`, `q1 = 0`.
3. **Mispredict.** Entry with `pnpc = 0x80000010` resolves `npc = 0x80000040`. Expect slot 1 blocked, `flush = 1` with `flush_pc = 0x80000040` the next cycle, then `count = 0` and `busy` all clear.
4. **Two stores.** Two adjacent stores in WB with `sq_ready = 1`. Expect one commit per cycle over 2 cycles. With `sq_ready = 0`, expect no commit.
5. **Rename race.** `rd = 3` commits while a same-cycle dispatch writes `rd = 3`. Expect `busy[3] = 1` and `reorder[3]` = new tag − 1.
6. **Wrap-around.** 20 dispatch/commit pairs at occupancy 3. Expect tags to wrap 8→1 and in-order `cm_pc` values.

Source files
------------

// File: rtl/ysyx_rob_pkg.sv
`default_nettype none
// ============================================================================
// ysyx_rob_pkg : shared types and helpers for the multi-commit reorder buffer
// Revision: 1.0
// ============================================================================
package ysyx_rob_pkg;

    typedef enum logic [1:0] {
        CM = 2'd0,
        WB = 2'd1,
        EX = 2'd2
    } rob_state_t;

    // Tag 0 is reserved for "no producer", so tags need one bit more than the index.
    function automatic int tagw(input int rob_size);
        return $clog2(rob_size) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_rob_rat.sv
`default_nettype none
// ============================================================================
// ysyx_rob_rat : register-alias table (busy bit + producing ROB index per reg)
// Revision: 1.0
// ============================================================================
module ysyx_rob_rat
    import ysyx_rob_pkg::*;
#(
    parameter int REG_NUM  = 16,
    parameter int ROB_SIZE = 8,
    parameter int CM_WIDTH = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clear_i,
    input  logic                              disp_en_i,
    input  logic [$clog2(REG_NUM)-1:0]        disp_rd_i,
    input  logic [$clog2(ROB_SIZE)-1:0]       disp_idx_i,
    input  logic [CM_WIDTH-1:0]               cm_en_i,
    input  logic [CM_WIDTH*$clog2(REG_NUM)-1:0]  cm_rd_i,
    input  logic [CM_WIDTH*$clog2(ROB_SIZE)-1:0] cm_idx_i,
    output logic [REG_NUM-1:0]                busy_o,
    output logic [REG_NUM*$clog2(ROB_SIZE)-1:0]  reorder_o
);

    localparam int RW   = $clog2(REG_NUM);
    localparam int IDXW = $clog2(ROB_SIZE);

    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;
    logic [IDXW-1:0]    reorder_q [REG_NUM];
    logic [IDXW-1:0]    reorder_d [REG_NUM];

    // Slots are visited in order so a later slot's index check wins; dispatch is applied last.
    always_comb begin
        busy_d    = busy_q;
        reorder_d = reorder_q;
        for (int s = 0; s < CM_WIDTH; s++) begin
            if (cm_en_i[s] && (reorder_q[cm_rd_i[s*RW +: RW]] == cm_idx_i[s*IDXW +: IDXW])) begin
                busy_d[cm_rd_i[s*RW +: RW]] = 1'b0;
            end
        end
        if (disp_en_i) begin
            busy_d[disp_rd_i]    = 1'b1;
            reorder_d[disp_rd_i] = disp_idx_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            busy_q <= '0;
            for (int r = 0; r < REG_NUM; r++) begin
                reorder_q[r] <= '0;
            end
        end else begin
            busy_q    <= busy_d;
            reorder_q <= reorder_d;
        end
    end

    assign busy_o = busy_q;

    for (genvar r = 0; r < REG_NUM; r++) begin : g_reorder_out
        assign reorder_o[r*IDXW +: IDXW] = reorder_q[r];
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_rob_mc.sv
`default_nettype none
// ============================================================================
// ysyx_rob_mc : reorder buffer with multi-port writeback, bypassed operand
//               lookup and up to two in-order commits per cycle
// Revision: 1.0
// ============================================================================
module ysyx_rob_mc
    import ysyx_rob_pkg::*;
#(
    parameter int ROB_SIZE = 8,
    parameter int REG_NUM  = 16,
    parameter int XLEN     = 32,
    parameter int WB_PORTS = 2,
    parameter int CM_WIDTH = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              disp_valid,
    output logic                              disp_ready,
    input  logic [4:0]                        disp_rd,
    input  logic [XLEN-1:0]                   disp_pc,
    input  logic [XLEN-1:0]                   disp_pnpc,
    input  logic                              disp_store,
    input  logic                              disp_fence_i,
    output logic [tagw(ROB_SIZE)-1:0]         disp_tag,
    input  logic [4:0]                        rs1,
    input  logic [4:0]                        rs2,
    output logic [tagw(ROB_SIZE)-1:0]         q1,
    output logic [tagw(ROB_SIZE)-1:0]         q2,
    output logic [XLEN-1:0]                   v1,
    output logic [XLEN-1:0]                   v2,
    output logic                              hit1,
    output logic                              hit2,
    input  logic [WB_PORTS-1:0]               wb_valid,
    input  logic [WB_PORTS*tagw(ROB_SIZE)-1:0] wb_tag,
    input  logic [WB_PORTS*XLEN-1:0]          wb_result,
    input  logic [WB_PORTS*XLEN-1:0]          wb_npc,
    input  logic [WB_PORTS-1:0]               wb_trap,
    input  logic                              sq_ready,
    output logic [CM_WIDTH-1:0]               cm_valid,
    output logic [CM_WIDTH*5-1:0]             cm_rd,
    output logic [CM_WIDTH*XLEN-1:0]          cm_result,
    output logic [CM_WIDTH*XLEN-1:0]          cm_pc,
    output logic [CM_WIDTH-1:0]               cm_store,
    output logic                              flush,
    output logic                              flush_trap,
    output logic [XLEN-1:0]                   flush_pc,
    output logic [tagw(ROB_SIZE)-1:0]         count
);

    localparam int TAGW = tagw(ROB_SIZE);
    localparam int IDXW = $clog2(ROB_SIZE);
    localparam int RW   = $clog2(REG_NUM);

    rob_state_t      state_q  [ROB_SIZE];
    logic [4:0]      rd_q     [ROB_SIZE];
    logic [XLEN-1:0] pc_q     [ROB_SIZE];
    logic [XLEN-1:0] pnpc_q   [ROB_SIZE];
    logic [XLEN-1:0] npc_q    [ROB_SIZE];
    logic [XLEN-1:0] result_q [ROB_SIZE];
    logic            store_q  [ROB_SIZE];
    logic            fence_q  [ROB_SIZE];
    logic            trap_q   [ROB_SIZE];

    logic [IDXW-1:0] head_q;
    logic [IDXW-1:0] tail_q;
    logic [TAGW-1:0] count_q;
    logic [TAGW-1:0] count_d;
    logic            flush_q;
    logic            flush_trap_q;
    logic [XLEN-1:0] flush_pc_q;

    logic            disp_fire;
    logic [IDXW-1:0] head1;
    logic            fire0;
    logic            fire1;
    logic            redir0;
    logic [IDXW-1:0] wb_idx [WB_PORTS];
    logic            wb_dup;

    logic [REG_NUM-1:0]      rat_busy;
    logic [REG_NUM*IDXW-1:0] rat_reorder;
    logic [CM_WIDTH*RW-1:0]  rat_cm_rd;
    logic [CM_WIDTH*IDXW-1:0] rat_cm_idx;

    // ---------------------------------------------------------------- dispatch
    assign disp_ready = (count_q != TAGW'(ROB_SIZE)) && !flush_q;
    assign disp_fire  = disp_valid && disp_ready;
    assign disp_tag   = TAGW'(tail_q) + TAGW'(1);

    // ---------------------------------------------------------------- commit
    assign head1 = head_q + IDXW'(1);

    always_comb begin
        fire0  = (state_q[head_q] == WB) && (!store_q[head_q] || sq_ready) && !flush_q;
        redir0 = fence_q[head_q] || trap_q[head_q] || (npc_q[head_q] != pnpc_q[head_q]);
        fire1  = (CM_WIDTH == 2) && fire0 && !redir0
                 && (state_q[head1] == WB) && !store_q[head1];
    end

    assign count_d = count_q + TAGW'(disp_fire) - TAGW'(fire0) - TAGW'(fire1);

    for (genvar s = 0; s < CM_WIDTH; s++) begin : g_slot
        logic [IDXW-1:0] idx;
        assign idx                         = head_q + IDXW'(s);
        assign cm_valid[s]                 = (s == 0) ? fire0 : fire1;
        assign cm_rd[s*5 +: 5]             = rd_q[idx];
        assign cm_result[s*XLEN +: XLEN]   = result_q[idx];
        assign cm_pc[s*XLEN +: XLEN]       = pc_q[idx];
        assign cm_store[s]                 = store_q[idx];
        assign rat_cm_rd[s*RW +: RW]       = rd_q[idx][RW-1:0];
        assign rat_cm_idx[s*IDXW +: IDXW]  = idx;
    end

    // ---------------------------------------------------------------- writeback
    for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb_idx
        assign wb_idx[p] = wb_tag[p*TAGW +: IDXW] - IDXW'(1);
    end

    always_comb begin
        wb_dup = 1'b0;
        for (int a = 0; a < WB_PORTS; a++) begin
            for (int b = a + 1; b < WB_PORTS; b++) begin
                if (wb_valid[a] && wb_valid[b] && (wb_tag[a*TAGW +: TAGW] == wb_tag[b*TAGW +: TAGW])) begin
                    wb_dup = 1'b1;
                end
            end
        end
    end

    a_wb_unique_tag: assert property (@(posedge clock) disable iff (reset) !wb_dup);

    // ---------------------------------------------------------------- state update
    always_ff @(posedge clock) begin
        if (reset || flush_q) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                state_q[i] <= CM;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            flush_q <= 1'b0;
            if (reset) begin
                flush_pc_q   <= '0;
                flush_trap_q <= 1'b0;
            end
        end else begin
            if (disp_fire) begin
                state_q[tail_q] <= EX;
                rd_q[tail_q]    <= disp_rd;
                pc_q[tail_q]    <= disp_pc;
                pnpc_q[tail_q]  <= disp_pnpc;
                store_q[tail_q] <= disp_store;
                fence_q[tail_q] <= disp_fence_i;
                trap_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + IDXW'(1);
            end
            // Later ports overwrite earlier ones when tags collide.
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && (wb_tag[p*TAGW +: TAGW] != '0) && (state_q[wb_idx[p]] == EX)) begin
                    state_q[wb_idx[p]]  <= WB;
                    result_q[wb_idx[p]] <= wb_result[p*XLEN +: XLEN];
                    npc_q[wb_idx[p]]    <= wb_npc[p*XLEN +: XLEN];
                    trap_q[wb_idx[p]]   <= wb_trap[p];
                end
            end
            if (fire0) begin
                state_q[head_q] <= CM;
            end
            if (fire1) begin
                state_q[head1] <= CM;
            end
            head_q  <= head_q + IDXW'(fire0) + IDXW'(fire1);
            count_q <= count_d;
            flush_q <= fire0 && redir0;
            if (fire0 && redir0) begin
                flush_pc_q   <= npc_q[head_q];
                flush_trap_q <= trap_q[head_q];
            end
        end
    end

    assign flush      = flush_q;
    assign flush_pc   = flush_pc_q;
    assign flush_trap = flush_trap_q;
    assign count      = count_q;

    // ---------------------------------------------------------------- alias table
    ysyx_rob_rat #(
        .REG_NUM  (REG_NUM),
        .ROB_SIZE (ROB_SIZE),
        .CM_WIDTH (CM_WIDTH)
    ) u_rat (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (flush_q),
        .disp_en_i  (disp_fire && (disp_rd != 5'd0)),
        .disp_rd_i  (disp_rd[RW-1:0]),
        .disp_idx_i (tail_q),
        .cm_en_i    (cm_valid),
        .cm_rd_i    (rat_cm_rd),
        .cm_idx_i   (rat_cm_idx),
        .busy_o     (rat_busy),
        .reorder_o  (rat_reorder)
    );

    // ---------------------------------------------------------------- operand lookup
    logic [4:0]      src_rs  [2];
    logic [IDXW-1:0] src_idx [2];
    logic [TAGW-1:0] src_tag [2];
    logic [TAGW-1:0] src_q   [2];
    logic            src_hit [2];
    logic [XLEN-1:0] src_v   [2];

    assign src_rs[0] = rs1;
    assign src_rs[1] = rs2;

    // A producer still in EX can be satisfied by a writeback landing this very cycle.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            src_idx[k] = rat_reorder[src_rs[k][RW-1:0]*IDXW +: IDXW];
            src_tag[k] = TAGW'(src_idx[k]) + TAGW'(1);
            src_q[k]   = '0;
            src_hit[k] = 1'b0;
            src_v[k]   = '0;
            if ((src_rs[k] != 5'd0) && rat_busy[src_rs[k][RW-1:0]]) begin
                if (state_q[src_idx[k]] == WB) begin
                    src_hit[k] = 1'b1;
                    src_v[k]   = result_q[src_idx[k]];
                end else begin
                    src_q[k] = src_tag[k];
                    for (int p = 0; p < WB_PORTS; p++) begin
                        if (wb_valid[p] && (wb_tag[p*TAGW +: TAGW] == src_tag[k])) begin
                            src_q[k]   = '0;
                            src_hit[k] = 1'b1;
                            src_v[k]   = wb_result[p*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    end

    assign q1   = src_q[0];
    assign q2   = src_q[1];
    assign hit1 = src_hit[0];
    assign hit2 = src_hit[1];
    assign v1   = src_v[0];
    assign v2   = src_v[1];

endmodule
`default_nettype wire
